// File: rtl/compmux_scan.sv
// compmux_scan: select controller in front of the 16:1 comparator output mux.
// Holds a static SPI channel or auto-scans enabled channels with settle blanking.
module compmux_scan #(
    parameter int N_CH    = 16,
    parameter int SEL_W   = 4,
    parameter int DWELL_W = 16,
    parameter int SETTLE  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               scan_en,
    input  logic [SEL_W-1:0]   static_sel,
    input  logic [N_CH-1:0]    ch_mask,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               restart,
    output logic [SEL_W-1:0]   mux_sel,
    output logic               sel_valid,
    output logic               ch_start,
    output logic               frame_start
);

    localparam int CNT_W = $clog2(SETTLE + 1);
    localparam logic [CNT_W-1:0]   SETTLE_LD = CNT_W'(SETTLE);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [DWELL_W-1:0] DW_ONE    = DWELL_W'(1);

    typedef enum logic [1:0] {
        ST_STATIC,
        ST_SETTLE,
        ST_DWELL,
        ST_EMPTY
    } state_e;

    typedef enum logic [3:0] {
        A_STATIC_LOAD,
        A_STATIC_NOW,
        A_SETTLE_TICK,
        A_SCAN_SELECT,
        A_SCAN_EMPTY,
        A_DWELL_BEGIN,
        A_DWELL_TICK,
        A_DWELL_REPEAT,
        A_DWELL_NEXT
    } act_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DWELL_W-1:0]   dlen_q, dlen_d;
    logic [DWELL_W-1:0]   dcnt_q, dcnt_d;
    logic                 tgt_scan_q, tgt_scan_d;
    logic                 frame_q, frame_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic                 valid_q, valid_d;
    logic                 cs_q, cs_d;
    logic                 fs_q, fs_d;

    act_e                 act;
    logic                 in_scan;
    logic                 enter;
    logic                 mask_any;
    logic                 static_chg;
    logic                 settle_done;
    logic                 dwell_done;
    logic                 wrap;
    logic [SEL_W-1:0]     first_idx;
    logic [SEL_W-1:0]     next_idx;
    logic [DWELL_W-1:0]   dwell_eff;

    // Lowest set bit of the mask; caller guards the all-zero case.
    function automatic logic [SEL_W-1:0] first_set(
        input logic [N_CH-1:0] m
    );
        logic [SEL_W-1:0] r;
        r = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (m[i]) r = SEL_W'(i);
        end
        return r;
    endfunction

    // Next set bit strictly above cur, wrapping; returns cur if it is alone.
    function automatic logic [SEL_W-1:0] next_set(
        input logic [N_CH-1:0]  m,
        input logic [SEL_W-1:0] cur
    );
        logic [SEL_W-1:0] r;
        logic [SEL_W-1:0] j;
        r = cur;
        for (int i = N_CH - 1; i >= 1; i--) begin
            j = cur + SEL_W'(i);
            if (m[j]) r = j;
        end
        return r;
    endfunction

    assign mask_any    = |ch_mask;
    assign first_idx   = first_set(ch_mask);
    assign next_idx    = next_set(ch_mask, sel_q);
    assign wrap        = (next_idx <= sel_q);
    assign static_chg  = (static_sel != sel_q);
    assign settle_done = (cnt_q == CNT_ONE);
    assign dwell_done  = (dcnt_q == DW_ONE);
    assign dwell_eff   = (dwell == '0) ? DW_ONE : dwell;
    assign in_scan     = (state_q == ST_DWELL) || (state_q == ST_EMPTY) ||
                         ((state_q == ST_SETTLE) && tgt_scan_q);
    assign enter       = scan_en && (!in_scan || restart);

    // Decide this cycle's transition; restart beats the dwell-end event.
    always_comb begin
        act = A_SCAN_EMPTY;
        if (!scan_en) begin
            if (static_chg)
                act = A_STATIC_LOAD;
            else if (in_scan || (state_q == ST_STATIC) || settle_done)
                act = A_STATIC_NOW;
            else
                act = A_SETTLE_TICK;
        end else if (enter || (state_q == ST_EMPTY)) begin
            act = mask_any ? A_SCAN_SELECT : A_SCAN_EMPTY;
        end else if (state_q == ST_SETTLE) begin
            act = settle_done ? A_DWELL_BEGIN : A_SETTLE_TICK;
        end else if (state_q == ST_DWELL) begin
            if (!dwell_done)
                act = A_DWELL_TICK;
            else if (!mask_any)
                act = A_SCAN_EMPTY;
            else if (next_idx == sel_q)
                act = A_DWELL_REPEAT;
            else
                act = A_DWELL_NEXT;
        end
    end

    // State and registered outputs, async active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_SETTLE;
            cnt_q      <= SETTLE_LD;
            dlen_q     <= DW_ONE;
            dcnt_q     <= DW_ONE;
            tgt_scan_q <= 1'b0;
            frame_q    <= 1'b0;
            sel_q      <= '0;
            valid_q    <= 1'b0;
            cs_q       <= 1'b0;
            fs_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dlen_q     <= dlen_d;
            dcnt_q     <= dcnt_d;
            tgt_scan_q <= tgt_scan_d;
            frame_q    <= frame_d;
            sel_q      <= sel_d;
            valid_q    <= valid_d;
            cs_q       <= cs_d;
            fs_q       <= fs_d;
        end
    end

    // Next-state: mode, settle/dwell counters and the frame flag.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dlen_d     = dlen_q;
        dcnt_d     = dcnt_q;
        tgt_scan_d = tgt_scan_q;
        frame_d    = frame_q;
        unique case (act)
            A_STATIC_LOAD: begin
                state_d    = ST_SETTLE;
                cnt_d      = SETTLE_LD;
                tgt_scan_d = 1'b0;
            end
            A_STATIC_NOW: begin
                state_d    = ST_STATIC;
                tgt_scan_d = 1'b0;
            end
            A_SETTLE_TICK: begin
                cnt_d = cnt_q - CNT_ONE;
            end
            A_SCAN_SELECT: begin
                state_d    = ST_SETTLE;
                cnt_d      = SETTLE_LD;
                tgt_scan_d = 1'b1;
                frame_d    = 1'b1;
                dlen_d     = dwell_eff;
            end
            A_SCAN_EMPTY: begin
                state_d = ST_EMPTY;
            end
            A_DWELL_BEGIN: begin
                state_d = ST_DWELL;
                dcnt_d  = dlen_q;
                frame_d = 1'b0;
            end
            A_DWELL_TICK: begin
                dcnt_d = dcnt_q - DW_ONE;
            end
            A_DWELL_REPEAT: begin
                dlen_d  = dwell_eff;
                dcnt_d  = dwell_eff;
                frame_d = 1'b0;
            end
            A_DWELL_NEXT: begin
                state_d    = ST_SETTLE;
                cnt_d      = SETTLE_LD;
                tgt_scan_d = 1'b1;
                frame_d    = wrap;
                dlen_d     = dwell_eff;
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    // Outputs: select load, blanking and boundary strobes.
    always_comb begin
        sel_d   = sel_q;
        valid_d = valid_q;
        cs_d    = 1'b0;
        fs_d    = 1'b0;
        unique case (act)
            A_STATIC_LOAD: begin
                sel_d   = static_sel;
                valid_d = 1'b0;
            end
            A_STATIC_NOW: begin
                valid_d = 1'b1;
            end
            A_SETTLE_TICK: begin
                valid_d = 1'b0;
            end
            A_SCAN_SELECT: begin
                sel_d   = first_idx;
                valid_d = 1'b0;
            end
            A_SCAN_EMPTY: begin
                valid_d = 1'b0;
            end
            A_DWELL_BEGIN: begin
                valid_d = 1'b1;
                cs_d    = 1'b1;
                fs_d    = frame_q;
            end
            A_DWELL_TICK: begin
                valid_d = 1'b1;
            end
            A_DWELL_REPEAT: begin
                valid_d = 1'b1;
                cs_d    = 1'b1;
                fs_d    = 1'b1;
            end
            A_DWELL_NEXT: begin
                sel_d   = next_idx;
                valid_d = 1'b0;
            end
            default: begin
                valid_d = valid_q;
            end
        endcase
    end

    assign mux_sel     = sel_q;
    assign sel_valid   = valid_q;
    assign ch_start    = cs_q;
    assign frame_start = fs_q;

    a_strobe_valid: assert property (
        @(posedge clk) disable iff (!rst_n) (cs_q || fs_q) |-> valid_q
    );
    a_frame_chan: assert property (
        @(posedge clk) disable iff (!rst_n) fs_q |-> cs_q
    );

endmodule

// File: tb/tb_compmux_scan.sv
// tb_compmux_scan: random + directed bench for compmux_scan.
// Cycle-level behavioural model compared on every falling edge.
module tb_compmux_scan;

    localparam int N_CH    = 16;
    localparam int SEL_W   = 4;
    localparam int DWELL_W = 16;
    localparam int SETTLE  = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               scan_en = 1'b0;
    logic               restart = 1'b0;
    logic [SEL_W-1:0]   static_sel = '0;
    logic [N_CH-1:0]    ch_mask = '0;
    logic [DWELL_W-1:0] dwell = '0;
    logic [SEL_W-1:0]   mux_sel;
    logic               sel_valid;
    logic               ch_start;
    logic               frame_start;

    int tests = 0;
    int fails = 0;

    compmux_scan #(
        .N_CH(N_CH), .SEL_W(SEL_W), .DWELL_W(DWELL_W), .SETTLE(SETTLE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .scan_en(scan_en),
        .static_sel(static_sel), .ch_mask(ch_mask), .dwell(dwell),
        .restart(restart), .mux_sel(mux_sel), .sel_valid(sel_valid),
        .ch_start(ch_start), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Model: mode 0 static, 1 scanning (blank_left>0 = blanking), 2 empty.
    int m_sel = 0;
    bit m_valid = 0, m_cs = 0, m_fs = 0;
    int m_mode = 0;
    int blank_left = SETTLE;
    int dwell_left = 1;
    int dwell_len = 1;
    bit frame_pend = 0;

    function automatic int eff(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    task automatic m_reset();
        m_sel = 0; m_valid = 0; m_cs = 0; m_fs = 0;
        m_mode = 0; blank_left = SETTLE; frame_pend = 0;
        dwell_left = 1; dwell_len = 1;
    endtask

    task automatic m_pick_first();
        int lo;
        lo = -1;
        for (int c = 0; c < N_CH; c++)
            if (ch_mask[c] && lo < 0) lo = c;
        if (lo < 0) begin
            m_mode = 2; m_valid = 0;
        end else begin
            m_mode = 1; m_sel = lo; blank_left = SETTLE; m_valid = 0;
            frame_pend = 1; dwell_len = eff(int'(dwell));
        end
    endtask

    task automatic m_advance();
        int lo, nxt;
        lo = -1; nxt = -1;
        for (int c = 0; c < N_CH; c++) begin
            if (ch_mask[c] && lo < 0) lo = c;
            if (ch_mask[c] && c > m_sel && nxt < 0) nxt = c;
        end
        if (lo < 0) begin
            m_mode = 2; m_valid = 0;
        end else begin
            if (nxt < 0) nxt = lo;
            if (nxt == m_sel) begin
                m_cs = 1; m_fs = 1;
                dwell_len = eff(int'(dwell)); dwell_left = dwell_len;
            end else begin
                frame_pend = (nxt < m_sel);
                m_sel = nxt; blank_left = SETTLE; m_valid = 0;
                dwell_len = eff(int'(dwell));
            end
        end
    endtask

    task automatic m_step();
        m_cs = 0; m_fs = 0;
        if (!scan_en) begin
            if (int'(static_sel) != m_sel) begin
                m_sel = int'(static_sel); blank_left = SETTLE; m_valid = 0;
            end else if (m_mode != 0 || blank_left <= 1) begin
                blank_left = 0; m_valid = 1;
            end else begin
                blank_left--;
            end
            m_mode = 0;
        end else if (m_mode == 0 || m_mode == 2 || restart) begin
            m_pick_first();
        end else if (blank_left > 0) begin
            blank_left--;
            if (blank_left == 0) begin
                m_valid = 1; m_cs = 1; m_fs = frame_pend; frame_pend = 0;
                dwell_left = dwell_len;
            end
        end else begin
            dwell_left--;
            if (dwell_left == 0) m_advance();
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_reset();
        else m_step();
    end

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        tests++;
        if ({mux_sel, sel_valid, ch_start, frame_start} !==
            {SEL_W'(m_sel), m_valid, m_cs, m_fs}) begin
            fails++;
            $display("FAIL cycle t=%0t: dut sel=%0d v=%0b cs=%0b fs=%0b, model sel=%0d v=%0b cs=%0b fs=%0b",
                     $time, mux_sel, sel_valid, ch_start, frame_start,
                     m_sel, m_valid, m_cs, m_fs);
        end
        tests++;
        if ((ch_start || frame_start) && !sel_valid) begin
            fails++;
            $display("FAIL strobe_without_valid t=%0t: cs=%0b fs=%0b v=%0b, required v=1",
                     $time, ch_start, frame_start, sel_valid);
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_cs(input int sel, input string name, output int n);
        n = 0;
        while (!(ch_start === 1'b1 && int'(mux_sel) == sel) && n < 200) begin
            step();
            n++;
        end
        check(name, 32'(n < 200), 1);
    endtask

    int cs_t[$];
    int cs_sel[$];
    int cs_fs[$];
    int exp_sel[4] = '{0, 1, 4, 0};
    int exp_fs[4]  = '{1, 0, 0, 1};
    int run;
    int n;

    initial begin
        // Reset, static select 5
        static_sel = 4'd5;
        step(); step();
        check("reset mux_sel", mux_sel, 0);
        check("reset sel_valid", sel_valid, 0);
        check("reset strobes", {ch_start, frame_start}, 0);
        rst_n = 1'b1;
        step();
        check("static mux_sel=5", mux_sel, 5);
        check("static blank1", sel_valid, 0);
        step();
        check("static blank2", sel_valid, 0);
        step();
        check("static valid", sel_valid, 1);
        check("static no strobes", {ch_start, frame_start}, 0);

        // Scan 0x0013, dwell 3
        ch_mask = 16'h0013; dwell = 16'd3; scan_en = 1'b1;
        for (int i = 1; i <= 26; i++) begin
            step();
            if (ch_start) begin
                cs_t.push_back(i);
                cs_sel.push_back(int'(mux_sel));
                cs_fs.push_back(int'(frame_start));
            end
        end
        check("scan ch_start count", 32'(cs_t.size() >= 4), 1);
        if (cs_t.size() >= 4) begin
            check("scan first ch_start cycle", cs_t[0], 3);
            for (int k = 0; k < 4; k++) begin
                check("scan sel order", cs_sel[k], exp_sel[k]);
                check("scan frame_start", cs_fs[k], exp_fs[k]);
                if (k > 0) check("scan period", cs_t[k] - cs_t[k-1], 5);
            end
        end

        // Single channel 8, dwell 0
        ch_mask = 16'h0100; dwell = 16'd0;
        run = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (mux_sel == 4'd8 && sel_valid && ch_start && frame_start)
                run++;
            else
                run = 0;
        end
        check("single-ch strobe run", 32'(run >= 15), 1);

        // Empty mask, then channel 15
        ch_mask = 16'h0000;
        step();
        check("empty valid", sel_valid, 0);
        step();
        check("empty hold sel", mux_sel, 8);
        check("empty no strobes", {ch_start, frame_start}, 0);
        ch_mask = 16'h8000;
        step();
        check("ch15 sel", mux_sel, 15);
        check("ch15 blank", sel_valid, 0);
        step();
        check("ch15 blank2", sel_valid, 0);
        step();
        check("ch15 start", {sel_valid, ch_start, frame_start}, 3'b111);

        // Mid-dwell mask change on channel 4
        ch_mask = 16'h0013; dwell = 16'd6; restart = 1'b1;
        step();
        restart = 1'b0;
        wait_cs(4, "reach ch4", n);
        ch_mask = 16'h0003;
        step();
        wait_cs(0, "wrap to ch0", n);
        check("wrap gap", n + 1, 8);
        check("wrap frame_start", frame_start, 1);
        wait_cs(1, "reach ch1", n);
        restart = 1'b1;
        step();
        restart = 1'b0;
        check("restart sel", mux_sel, 0);
        check("restart blank", sel_valid, 0);
        step();
        check("restart blank2", sel_valid, 0);
        step();
        check("restart start", {sel_valid, ch_start, frame_start}, 3'b111);

        // Drop scan_en on channel 4
        ch_mask = 16'h0010; restart = 1'b1;
        step();
        restart = 1'b0;
        step(); step();
        check("ch4 dwell", {mux_sel, ch_start}, {4'd4, 1'b1});
        static_sel = 4'd4; scan_en = 1'b0;
        step();
        check("static same sel", mux_sel, 4);
        check("static same valid", sel_valid, 1);
        for (int i = 0; i < 3; i++) begin
            check("static strobes off", {ch_start, frame_start}, 0);
            step();
        end
        scan_en = 1'b1;
        step(); step(); step();
        check("ch4 again", {mux_sel, ch_start}, {4'd4, 1'b1});
        static_sel = 4'd9; scan_en = 1'b0;
        step();
        check("static 9 sel", mux_sel, 9);
        check("static 9 blank", sel_valid, 0);
        step();
        check("static 9 blank2", sel_valid, 0);
        step();
        check("static 9 valid", sel_valid, 1);
        static_sel = 4'd2;
        step();
        check("static 2 settle", {mux_sel, sel_valid}, {4'd2, 1'b0});
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset outputs",
              {mux_sel, sel_valid, ch_start, frame_start}, 0);
        step();
        rst_n = 1'b1;

        // Randomized traffic
        scan_en = 1'b1;
        ch_mask = 16'h00A5;
        for (int i = 0; i < 4000; i++) begin
            restart = 1'b0;
            if ($urandom_range(0, 59) == 0) scan_en = ~scan_en;
            if ($urandom_range(0, 29) == 0)
                static_sel = SEL_W'($urandom_range(0, N_CH - 1));
            if ($urandom_range(0, 49) == 0) begin
                case ($urandom_range(0, 3))
                    0: ch_mask = '0;
                    1: begin
                        ch_mask = '0;
                        ch_mask[$urandom_range(0, N_CH - 1)] = 1'b1;
                    end
                    default: ch_mask = N_CH'($urandom);
                endcase
            end
            if ($urandom_range(0, 39) == 0)
                dwell = DWELL_W'($urandom_range(0, 5));
            if ($urandom_range(0, 39) == 0) restart = 1'b1;
            rst_n = ($urandom_range(0, 799) == 0) ? 1'b0 : 1'b1;
            step();
        end
        rst_n = 1'b1;
        restart = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
